sdram_wb_reader: RTL

Pipelined Wishbone read master that pulls a contiguous block of 32-bit words out of SDRAM through the `sdram` controller's slave port. It pushes each returned word into a downstream FIFO toward the FT600 / AFE TX path. It is the read-side counterpart of the SDRAM write traffic: it shares the `sdram` Wishbone port and runs in the `clk_pll` domain. A block transfer is started by a single-cycle command and acknowledged with a done pulse.

---
 rtl/sdr_pkg.sv | 17 +
 rtl/wb_ack_watchdog.sv | 38 +++
 rtl/sdram_wb_reader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sdr_pkg.sv
// Shared SDRAM-side definitions.
// Holds the Wishbone address/data widths used by sdram, sdram_test_wb and
// sdram_wb_reader, plus the state encoding of the block reader FSM.
package sdr_pkg;

    // Wishbone word address and data widths of the sdram slave port.
    localparam int SDR_ADDR_WIDTH = 24;
    localparam int SDR_DATA_WIDTH = 32;

    // Block reader states.
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Acknowledge watchdog for a Wishbone master.
// Counts cycles while 'enable' is high (requests outstanding) and raises
// 'expire' once TIMEOUT_CYCLES cycles have passed without a 'clear'.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clear      restarts the count (an ack, or the start of a new block)
//   enable     count only while at least one request is outstanding
//   expire     single-cycle indication that the limit was reached
module wb_ack_watchdog #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && count_reg != LAST) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Fires in the cycle that completes TIMEOUT_CYCLES idle cycles; the
    // owner leaves its busy state on the following edge.
    assign expire = enable && !clear && (count_reg == LAST);

endmodule

// File: rtl/sdram_wb_reader.sv
// Pipelined Wishbone block reader.
// Reads len_i consecutive 32-bit words starting at addr_i from the sdram
// slave port and forwards every returned word to a downstream FIFO.
// Optional feature: define SDRAM_WB_READER_TIMEOUT_EN to add an ack
// watchdog (wb_ack_watchdog) that aborts a stuck transfer and sets err_o.
// Ports:
//   clk_i, rst_i            clock (clk_pll) and async active-high reset
//   start_i/addr_i/len_i    block command, accepted only while idle
//   busy_o, done_o, err_o   status: in progress, completion pulse, sticky error
//   cyc_o/stb_o/we_o/adr_o/sel_o, stall_i/ack_i/dat_i
//                           Wishbone pipelined read master
//   fifo_afull_i            downstream almost-full, gates new requests only
//   fifo_wr_o/fifo_data_o   downstream write port
module sdram_wb_reader
    import sdr_pkg::*;
#(
    parameter int ADDR_WIDTH      = SDR_ADDR_WIDTH,
    parameter int DATA_WIDTH      = SDR_DATA_WIDTH,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    cyc_o,
    output logic                    stb_o,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH/8-1:0] sel_o,
    input  logic                    stall_i,
    input  logic                    ack_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic                    fifo_afull_i,
    output logic                    fifo_wr_o,
    output logic [DATA_WIDTH-1:0]   fifo_data_o
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    rd_state_t             state_reg,  state_next;
    logic [ADDR_WIDTH-1:0] adr_reg,    adr_next;
    logic [LEN_WIDTH-1:0]  remain_reg, remain_next;   // requests still to issue
    logic [OUT_W-1:0]      outst_reg,  outst_next;    // issued, not yet acked
    logic                  stb_reg,    stb_next;
    logic                  done_reg,   done_next;
    logic                  wr_reg;
    logic [DATA_WIDTH-1:0] data_reg;

    logic accept;
    logic ack_ok;

    assign accept = stb_reg && !stall_i;
    // Acks outside a transfer (e.g. stragglers after a reset) are dropped.
    assign ack_ok = ack_i && (state_reg != RD_IDLE) && (outst_reg != '0);

`ifdef SDRAM_WB_READER_TIMEOUT_EN
    logic err_reg, err_next;
    logic start_issue;
    logic expire;

    wb_ack_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk_i),
        .rst    (rst_i),
        .clear  (ack_i || start_issue),
        .enable ((state_reg != RD_IDLE) && (outst_reg != '0)),
        .expire (expire)
    );
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= RD_IDLE;
            adr_reg    <= '0;
            remain_reg <= '0;
            outst_reg  <= '0;
            stb_reg    <= 1'b0;
            done_reg   <= 1'b0;
            wr_reg     <= 1'b0;
            data_reg   <= '0;
`ifdef SDRAM_WB_READER_TIMEOUT_EN
            err_reg    <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            adr_reg    <= adr_next;
            remain_reg <= remain_next;
            outst_reg  <= outst_next;
            stb_reg    <= stb_next;
            done_reg   <= done_next;
            wr_reg     <= ack_ok;
            if (ack_ok) begin
                data_reg <= dat_i;
            end
`ifdef SDRAM_WB_READER_TIMEOUT_EN
            err_reg    <= err_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        adr_next    = adr_reg;
        remain_next = remain_reg;
        outst_next  = outst_reg + OUT_W'(accept) - OUT_W'(ack_ok);
        stb_next    = stb_reg;
        done_next   = 1'b0;
`ifdef SDRAM_WB_READER_TIMEOUT_EN
        err_next    = err_reg;
        start_issue = 1'b0;
`endif

        unique case (state_reg)
            RD_IDLE: begin
                outst_next = '0;
                stb_next   = 1'b0;
                if (start_i) begin
`ifdef SDRAM_WB_READER_TIMEOUT_EN
                    err_next = 1'b0;
`endif
                    if (len_i != '0) begin
                        adr_next    = addr_i;
                        remain_next = len_i;
                        stb_next    = !fifo_afull_i;
                        state_next  = RD_ISSUE;
`ifdef SDRAM_WB_READER_TIMEOUT_EN
                        start_issue = 1'b1;
`endif
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end

            RD_ISSUE: begin
                if (accept) begin
                    adr_next    = adr_reg + 1'b1;
                    remain_next = remain_reg - 1'b1;
                end
                // A stalled request must stay on the bus unchanged; otherwise
                // the next strobe is decided from post-cycle credit and the
                // almost-full seen this cycle, so it reacts one cycle later.
                if (stb_reg && stall_i) begin
                    stb_next = 1'b1;
                end else begin
                    stb_next = (remain_next != '0) && (outst_next < OUT_MAX)
                               && !fifo_afull_i;
                end
                if (accept && remain_reg == LEN_WIDTH'(1)) begin
                    state_next = RD_DRAIN;
                end
            end

            RD_DRAIN: begin
                stb_next = 1'b0;
                if (outst_next == '0) begin
                    state_next = RD_IDLE;
                    done_next  = 1'b1;
                end
            end

            default: begin
                state_next = RD_IDLE;
                stb_next   = 1'b0;
            end
        endcase

`ifdef SDRAM_WB_READER_TIMEOUT_EN
        if (expire) begin
            state_next = RD_IDLE;
            stb_next   = 1'b0;
            outst_next = '0;
            err_next   = 1'b1;
            done_next  = 1'b1;
        end
`endif
    end

    assign busy_o      = (state_reg != RD_IDLE);
    assign cyc_o       = (state_reg != RD_IDLE);
    assign stb_o       = stb_reg;
    assign we_o        = 1'b0;
    assign adr_o       = adr_reg;
    assign sel_o       = '1;
    assign done_o      = done_reg;
    assign fifo_wr_o   = wr_reg;
    assign fifo_data_o = data_reg;

`ifdef SDRAM_WB_READER_TIMEOUT_EN
    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
    // The watchdog limit only matters when the watchdog is built.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule
